// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core.
// Decodes the instruction held in IR and sequences the shared memory/ALU
// datapath through fetch, decode, execute, memory and writeback. Every select
// is a Moore decode of the state register. The one exception is PcEn in BRANCH,
// which also follows the live ALU Zero flag.
module multicycle_controller #(
  parameter int ALUOP_W      = 3,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        Inst,
  input  logic               Zero,
  output logic               PcEn,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IrWrite,
  output logic               RegWrite,
  output logic [2:0]         ImmSrc,
  output logic [1:0]         AluSrcA,
  output logic [1:0]         AluSrcB,
  output logic [ALUOP_W-1:0] AluOp,
  output logic [1:0]         ResultSrc,
  output logic               illegal
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13,
    S_ILLEGAL   = 4'd14
  } state_t;

  localparam logic [6:0] OP_LW   = 7'h03;
  localparam logic [6:0] OP_SW   = 7'h23;
  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_LUI  = 7'h37;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'd0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'd1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'd2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'd3);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(3'd4);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'd5);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(3'd6);
  localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(3'd7);

  state_t state_q, state_d;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       f7b5_s;
  logic       unused_inst_s;
  logic       pc_en_s, mem_write_s, ir_write_s, reg_write_s;

  assign opcode_s      = Inst[6:0];
  assign funct3_s      = Inst[14:12];
  assign f7b5_s        = Inst[30];
  assign unused_inst_s = ^{Inst[31], Inst[29:15], Inst[11:7]};

  // ALU operation from funct3. The subtract variant of 000 exists only for R-type.
  function automatic logic [ALUOP_W-1:0] alu_decode(input logic [2:0] f3, input logic sub_sel);
    logic [ALUOP_W-1:0] op;
    case (f3)
      3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b100:  op = ALU_XOR;
      3'b010:  op = ALU_SLT;
      3'b001:  op = ALU_SLL;
      3'b101:  op = ALU_SRL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // State register: reset aborts any instruction in flight and restarts at FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing. Dispatch happens in DECODE, once IR holds the new instruction.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_s)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR;
          OP_LUI:       state_d = S_LUI;
          default: begin
            if (TRAP_ILLEGAL) begin
              state_d = S_ILLEGAL;
            end else begin
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode_s == OP_LW) begin
          state_d = S_MEMREAD;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD:   state_d = S_MEMWB;
      S_MEMWB:     state_d = S_FETCH;
      S_MEMWRITE:  state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALUWB;
      S_EXEC_I:    state_d = S_ALUWB;
      S_ALUWB:     state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL:       state_d = S_ALUWB;
      S_JALR:      state_d = S_JALR_LINK;
      S_JALR_LINK: state_d = S_ALUWB;
      S_LUI:       state_d = S_ALUWB;
      S_ILLEGAL:   state_d = S_ILLEGAL;
      default:     state_d = S_FETCH;
    endcase
  end

  // Datapath control decode. Anything a state does not mention stays 0 or add.
  always_comb begin
    pc_en_s     = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    AdrSrc      = 1'b0;
    ImmSrc      = 3'b000;
    AluSrcA     = 2'b00;
    AluSrcB     = 2'b00;
    AluOp       = ALU_ADD;
    ResultSrc   = 2'b00;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_en_s    = 1'b1;
        AluSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      S_DECODE: begin
        // The branch target, or the jal target, is precomputed into AluOutReg.
        AluSrcA = 2'b01;
        AluSrcB = 2'b01;
        if (opcode_s == OP_JAL) begin
          ImmSrc = 3'b100;
        end else begin
          ImmSrc = 3'b010;
        end
      end
      S_MEMADR: begin
        AluSrcA = 2'b10;
        AluSrcB = 2'b01;
        if (opcode_s == OP_SW) begin
          ImmSrc = 3'b001;
        end else begin
          ImmSrc = 3'b000;
        end
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXEC_R: begin
        AluSrcA = 2'b10;
        AluOp   = alu_decode(funct3_s, f7b5_s);
      end
      S_EXEC_I: begin
        AluSrcA = 2'b10;
        AluSrcB = 2'b01;
        AluOp   = alu_decode(funct3_s, 1'b0);
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        // Compare rs1/rs2; the PC loads the target held in AluOutReg when taken.
        AluSrcA = 2'b10;
        case (funct3_s)
          3'b000: begin AluOp = ALU_SUB; pc_en_s = Zero;  end
          3'b001: begin AluOp = ALU_SUB; pc_en_s = ~Zero; end
          3'b100: begin AluOp = ALU_SLT; pc_en_s = ~Zero; end
          3'b101: begin AluOp = ALU_SLT; pc_en_s = Zero;  end
          default: begin AluOp = ALU_ADD; pc_en_s = 1'b0; end
        endcase
      end
      S_JAL: begin
        AluSrcA = 2'b01;
        AluSrcB = 2'b10;
        pc_en_s = 1'b1;
      end
      S_JALR: begin
        AluSrcA   = 2'b10;
        AluSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_en_s   = 1'b1;
      end
      S_JALR_LINK: begin
        AluSrcA = 2'b01;
        AluSrcB = 2'b10;
      end
      S_LUI: begin
        AluSrcA = 2'b11;
        AluSrcB = 2'b01;
        ImmSrc  = 3'b011;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

  // While reset is held, every write enable is forced off, whatever the state.
  assign PcEn     = pc_en_s & rst;
  assign MemWrite = mem_write_s & rst;
  assign IrWrite  = ir_write_s & rst;
  assign RegWrite = reg_write_s & rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. It compares the full control word
// against hand-written values in every state of each instruction.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Inst;
  logic        Zero;
  logic        PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, illegal;
  logic [2:0]  ImmSrc, AluOp;
  logic [1:0]  AluSrcA, AluSrcB, ResultSrc;
  logic [17:0] ctrl_s;

  int total = 0;
  int bad   = 0;

  multicycle_controller #(.ALUOP_W(3), .TRAP_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .Inst(Inst), .Zero(Zero),
    .PcEn(PcEn), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IrWrite(IrWrite),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
    .AluOp(AluOp), .ResultSrc(ResultSrc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign ctrl_s = {PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, ImmSrc,
                   AluSrcA, AluSrcB, AluOp, ResultSrc, illegal};

  function automatic logic [17:0] cv(input logic pc, input logic adr, input logic mw,
                                     input logic ir, input logic rw, input logic [2:0] imm,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] op, input logic [1:0] rs,
                                     input logic il);
    return {pc, adr, mw, ir, rw, imm, a, b, op, rs, il};
  endfunction

  task automatic chk(input string tag, input logic [17:0] exp);
    total++;
    assert (ctrl_s === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, ctrl_s, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [17:0] c_fetch, c_rst, c_dec_b, c_dec_j, c_madr_lw, c_madr_sw, c_mread, c_mwb;
  logic [17:0] c_mwrite, c_aluwb, c_sub, c_and, c_beq_t, c_beq_n, c_bge_t, c_jal, c_ill;

  initial begin
    c_fetch   = cv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd2, 3'd0, 2'd2, 1'b0);
    c_rst     = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd2, 3'd0, 2'd2, 1'b0);
    c_dec_b   = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'd1, 2'd1, 3'd0, 2'd0, 1'b0);
    c_dec_j   = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 2'd1, 2'd1, 3'd0, 2'd0, 1'b0);
    c_madr_lw = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0);
    c_madr_sw = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0);
    c_mread   = cv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
    c_mwb     = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 3'd0, 2'd1, 1'b0);
    c_mwrite  = cv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
    c_aluwb   = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0);
    c_sub     = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd0, 3'd1, 2'd0, 1'b0);
    c_and     = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd0, 3'd2, 2'd0, 1'b0);
    c_beq_t   = cv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd0, 3'd1, 2'd0, 1'b0);
    c_beq_n   = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd0, 3'd1, 2'd0, 1'b0);
    c_bge_t   = cv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd2, 2'd0, 3'd5, 2'd0, 1'b0);
    c_jal     = cv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 2'd2, 3'd0, 2'd0, 1'b0);
    c_ill     = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b1);

    // Reset held for three clocks: FETCH selects, all enables off.
    rst  = 1'b0;
    Zero = 1'b0;
    Inst = 32'h0080A283;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", c_rst);
    end
    rst = 1'b1;
    #1;
    chk("fetch_after_release", c_fetch);

    // lw x5,8(x1): F D MEMADR MEMREAD MEMWB.
    step(); chk("lw_decode", c_dec_b);
    step(); chk("lw_memadr", c_madr_lw);
    step(); chk("lw_memread", c_mread);
    step(); chk("lw_memwb", c_mwb);

    // sw: F D MEMADR MEMWRITE.
    step(); Inst = 32'h0050A423; chk("sw_fetch", c_fetch);
    step(); chk("sw_decode", c_dec_b);
    step(); chk("sw_memadr", c_madr_sw);
    step(); chk("sw_memwrite", c_mwrite);

    // beq taken (Zero=1).
    step(); Inst = 32'h00208463; Zero = 1'b1; chk("beq_t_fetch", c_fetch);
    step(); chk("beq_t_decode", c_dec_b);
    step(); chk("beq_t_branch", c_beq_t);

    // beq not taken (Zero=0).
    step(); Zero = 1'b0; chk("beq_n_fetch", c_fetch);
    step(); chk("beq_n_decode", c_dec_b);
    step(); chk("beq_n_branch", c_beq_n);

    // bge with Zero=1 is taken.
    step(); Inst = 32'h0020D463; Zero = 1'b1; chk("bge_fetch", c_fetch);
    step(); chk("bge_decode", c_dec_b);
    step(); chk("bge_branch", c_bge_t);

    // sub x3,x1,x2.
    step(); Inst = 32'h402081B3; Zero = 1'b0; chk("sub_fetch", c_fetch);
    step(); chk("sub_decode", c_dec_b);
    step(); chk("sub_exec", c_sub);
    step(); chk("sub_aluwb", c_aluwb);

    // and x3,x1,x2.
    step(); Inst = 32'h0020F1B3; chk("and_fetch", c_fetch);
    step(); chk("and_decode", c_dec_b);
    step(); chk("and_exec", c_and);
    step(); chk("and_aluwb", c_aluwb);

    // jal: the target uses the J immediate in DECODE.
    step(); Inst = 32'h008000EF; chk("jal_fetch", c_fetch);
    step(); chk("jal_decode", c_dec_j);
    step(); chk("jal_jal", c_jal);
    step(); chk("jal_aluwb", c_aluwb);

    // Reset asserted mid-lw, in MEMWB: RegWrite must drop at once.
    step(); Inst = 32'h0080A283; chk("lw2_fetch", c_fetch);
    step(); step(); step();
    chk("lw2_memread", c_mread);
    step(); chk("lw2_memwb", c_mwb);
    rst = 1'b0;
    #1;
    chk("abort_reset", c_rst);
    step(); chk("abort_hold", c_rst);
    rst = 1'b1;
    #1;
    chk("abort_fetch", c_fetch);

    // Unknown opcode traps until reset.
    Inst = 32'h0000007F;
    step(); chk("ill_decode", c_dec_b);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ill_park", c_ill);
    end
    rst = 1'b0;
    #1;
    chk("ill_reset", c_rst);
    step();
    rst = 1'b1;
    #1;
    chk("ill_recover_fetch", c_fetch);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
